// File: rtl/ct_ifu_spsram_512x44_ctrl.sv
// Front-end controller for the IFU 512x44 single-port SRAM. It sweeps the array
// after reset or invalidate, arbitrates write-over-read and returns read data one cycle later.
module ct_ifu_spsram_512x44_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 44,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  inv_req,
  output logic                  inv_busy,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_mask,
  output logic                  wr_grant,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_idx,
  output logic                  rd_grant,
  output logic                  rd_data_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic [DATA_WIDTH-1:0] rd_hold;
  logic                  sweep_last;

  assign sweep_last = &init_cnt;
  assign inv_busy   = (state != RUN);

  // The sweep counter wraps to zero on its last write, so a later invalidate starts at entry 0.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state    <= IDLE;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT)
        init_cnt <= init_cnt + ADDR_WIDTH'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    wr_grant  = 1'b0;
    rd_grant  = 1'b0;
    sram_a    = '0;
    sram_d    = '0;
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    case (state)
      IDLE: state_nxt = INIT;
      INIT: begin
        sram_a    = init_cnt;
        sram_d    = INIT_VAL;
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = '0;
        if (sweep_last)
          state_nxt = RUN;
      end
      RUN: begin
        // Invalidate outranks every requestor; the pending requests simply wait out the sweep.
        if (inv_req) begin
          state_nxt = INIT;
        end else if (wr_req) begin
          wr_grant  = 1'b1;
          sram_a    = wr_idx;
          sram_d    = wr_data;
          sram_wen  = ~wr_mask;
          sram_gwen = 1'b0;
          sram_cen  = 1'b0;
        end else if (rd_req) begin
          rd_grant = 1'b1;
          sram_a   = rd_idx;
          sram_cen = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A granted read always returns next cycle, even if an invalidate arrives meanwhile.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rd_data_vld <= 1'b0;
      rd_hold     <= '0;
    end else begin
      rd_data_vld <= rd_grant;
      if (rd_data_vld)
        rd_hold <= sram_q;
    end
  end

  assign rd_data = rd_data_vld ? sram_q : rd_hold;

endmodule

// File: doc/ct_ifu_spsram_512x44_ctrl.md
# ct_ifu_spsram_512x44_ctrl

Front-end controller that sits directly upstream of the IFU 512x44 single-port SRAM and owns all of its control pins. It sweeps the whole array to a known value after reset or on an invalidate request. It arbitrates one write or one read per cycle from IFU requestors and returns read data with a valid pulse. All SRAM pins it drives (address, chip enable, global and per-bit write enables, data) are active-low where the SRAM expects it.

## Interface
- ADDR_WIDTH, 9, SRAM index width (depth 512)
- DATA_WIDTH, 44, SRAM entry width
- INIT_VAL, 44'h0, value written to every entry during a sweep

- forever_cpuclk  in  1  clock; all state updates on rising edge
- cpurst_b  in  1  reset, asynchronous, active-low
- inv_req  in  1  pulse: start a full-array invalidate sweep
- inv_busy  out  1  high while not in RUN (reset, IDLE, INIT)
- wr_req  in  1  write request
- wr_idx  in  ADDR_WIDTH  write index
- wr_data  in  DATA_WIDTH  write data
- wr_mask  in  DATA_WIDTH  per-bit write enable, 1 = write bit
- wr_grant  out  1  write accepted this cycle
- rd_req  in  1  read request
- rd_idx  in  ADDR_WIDTH  read index
- rd_grant  out  1  read accepted this cycle
- rd_data_vld  out  1  read data valid (one cycle after rd_grant)
- rd_data  out  DATA_WIDTH  read data, held until next rd_data_vld
- sram_a  out  ADDR_WIDTH  SRAM address
- sram_cen  out  1  SRAM chip enable, active-low
- sram_gwen  out  1  SRAM global write enable, active-low
- sram_wen  out  DATA_WIDTH  SRAM per-bit write enable, active-low
- sram_d  out  DATA_WIDTH  SRAM write data
- sram_q  in  DATA_WIDTH  SRAM read data, valid the cycle after a read access

## Operation
- States: IDLE, INIT, RUN. Reset state is IDLE, sweep counter init_cnt = 0.
- IDLE -> INIT unconditionally on the first edge after reset release.
- INIT:
  - Each cycle drives a write of INIT_VAL to address init_cnt: sram_cen=0, sram_gwen=0, sram_wen=all 0.
  - init_cnt increments by 1. On the edge where init_cnt==511, the state moves to RUN and init_cnt returns to 0 (wrap).
  - No grants are issued; wr_req and rd_req are ignored and must be held by the requestor.
  - inv_req is ignored; the sweep does not restart.
- RUN:
  - inv_req has highest priority. If asserted: no grant, no SRAM access, and the next state is INIT.
  - Otherwise a write beats a read. wr_grant = wr_req. rd_grant = rd_req & ~wr_req.
  - On a write, sram_a=wr_idx, sram_d=wr_data, sram_wen=~wr_mask, sram_gwen=0, sram_cen=0.
  - On a read, sram_a=rd_idx, sram_gwen=1, sram_wen=all 1, sram_cen=0.
  - With no access, sram_cen=1, sram_gwen=1, sram_wen=all 1.
- Grants and SRAM pins are combinational from the current state and requests.
- Read return:
  - rd_data_vld is a flop set to rd_grant.
  - When rd_data_vld=1, rd_data = sram_q and that value is captured into a hold register.
  - When rd_data_vld=0, rd_data = hold register.
- A read granted in cycle N returns in N+1 even if inv_req is seen in N+1.
- Asynchronous reset mid-sweep or mid-read returns the block to IDLE, init_cnt to 0 and rd_data_vld to 0. A full sweep restarts after release.

## Timing
- Reset values:
  - inv_busy=1, wr_grant=0, rd_grant=0, rd_data_vld=0, rd_data=0.
  - sram_cen=1, sram_gwen=1, sram_wen=all 1, sram_a=0, sram_d=0.
- Sweep: edge 1 after release enters INIT. Addresses 0..511 are written in cycles 1..512. The state is RUN, with inv_busy=0, from cycle 513.
- Read latency is 1 cycle from grant to rd_data_vld. Throughput is 1 access per cycle.
- A write to index X in cycle N followed by a read of X in N+1 returns the new data in N+2.
- An inv_req in RUN at cycle N puts the block in INIT at N+1 and in RUN again at N+513.

## Test plan
- Reset release -> sram writes INIT_VAL at addresses 0..511 in consecutive cycles; inv_busy falls exactly 513 cycles after release; no grants during the sweep.
- RUN: write idx 5, data 44'hABC, mask all 1 at N; read idx 5 at N+1 -> rd_data_vld=1 at N+2 with rd_data=44'hABC; rd_data holds 44'hABC afterwards.
- Partial mask: entry 7 = all-1s, write 44'h0 with mask 44'hF -> read returns 44'hFFF_FFFF_FFF0.
- wr_req and rd_req together -> wr_grant=1, rd_grant=0; read granted the next cycle once wr_req drops.
- inv_req together with rd_req in RUN -> no grant, INIT next cycle, then a read of idx 5 after the sweep returns INIT_VAL.
- Assert cpurst_b=0 at sweep count 200 -> outputs at reset values immediately; after release the sweep restarts at address 0 and runs all 512 entries.
